macro_bus_arbiter: RTL and testbench
====================================

Name: macro_bus_arbiter

Overview:
Shares the single Caravel Wishbone slave port and the 38 user IO pads among N_MACRO user macros (macro_7, macro_10, macro_13, macro_15, ...). Address-decodes each Wishbone transaction to exactly one macro and forwards it. Returns that macro's data and ack, with a bounded-latency timeout. Holds per-macro enable bits (drive each macro's active input) and an IO-owner register that selects which macro drives io_out/io_oeb.

Parameters:
N_MACRO, 4, number of macro slots (1..15)
TIMEOUT, 255, cycles in FWD without a macro ack before an error response
IO_W, 38, IO pad width
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout
BAD_DATA, 32'hBADD_ADD0, read data returned for an invalid or disabled slot

Ports:
wb_clk_i  in  1  clock
wb_rst_n  in  1  synchronous active-low reset
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone master request
wbs_sel_i  in  4  byte select
wbs_adr_i, wbs_dat_i  in  32 each  address, write data
wbs_ack_o  out  1  ack, one cycle per transaction
wbs_dat_o  out  32  read data
m_cyc_o, m_stb_o  out  N_MACRO each  one-hot per-macro request
m_we_o, m_sel_o, m_adr_o, m_dat_o  out  1/4/32/32  broadcast copies of the master signals
m_dat_i  in  N_MACRO*32  per-macro read data
m_ack_i  in  N_MACRO  per-macro ack
m_active_o  out  N_MACRO  ENABLE register bits
m_io_out_i, m_io_oeb_i  in  N_MACRO*IO_W each  per-macro pad drive
io_out, io_oeb  out  IO_W each  pad drive to the wrapper

Behaviour:
- Reset is synchronous, active-low, on the clock edge where wb_rst_n=0. Taken in any state, including mid-FWD.
- Reset values:
  - state=IDLE; wbs_ack_o=0; wbs_dat_o=0; m_cyc_o=0; m_stb_o=0.
  - ENABLE=0, so m_active_o=0. IO_OWNER=0. TO_CNT=0.
  - io_out=0; io_oeb=all 1.
- Address decode applies only when adr[31:24]==8'h30; any other value is invalid. slot=adr[23:20].
  - slot 4'hF: control registers, decoded on adr[3:2]:
    - 0 ENABLE (RW, N_MACRO bits).
    - 1 IO_OWNER (RW, 4 bits).
    - 2 TO_CNT (RO, 8-bit saturating timeout count; any write clears it).
    - 3 reads 0; writes ignored.
  - slot < N_MACRO with ENABLE[slot]=1: macro transaction.
  - Anything else: invalid.
- States:
  - IDLE, on cyc&stb:
    - Control: perform the register write, or capture the read value, then go to RESP.
    - Valid macro slot: latch sel, assert m_cyc_o[sel] and m_stb_o[sel] from the next cycle, clear the counter, go to FWD.
    - Invalid: wbs_dat_o=BAD_DATA, go to RESP; writes are dropped.
  - FWD: hold m_cyc_o/m_stb_o on sel only. Ack from any other macro is ignored.
    - m_ack_i[sel]=1: latch m_dat_i[sel], drop m_stb_o/m_cyc_o in the next cycle, go to RESP.
    - counter==TIMEOUT-1 with no ack: wbs_dat_o=ERR_DATA, TO_CNT+=1 (saturates at 255), drop the macro request, go to RESP.
    - wbs_cyc_i=0: abort to IDLE, drop the macro request, no ack.
    - Ack and timeout in the same cycle: ack wins.
  - RESP: wbs_ack_o=1 for exactly one cycle, then IDLE. A new request is not sampled in the RESP cycle.
- Latency:
  - Control or invalid access: request at cycle 0, wbs_ack_o at cycle 1.
  - Macro access: m_stb_o at cycle 1; macro ack at cycle k gives wbs_ack_o at cycle k+1.
- wbs_dat_o holds its value between transactions; only the value in the ack cycle is meaningful.
- IO mux (registered, 1-cycle latency):
  - If IO_OWNER<N_MACRO and ENABLE[IO_OWNER]=1: io_out/io_oeb follow the owner's slices.
  - Otherwise io_out=0 and io_oeb=all 1.
- Clearing the ENABLE bit of the macro that is mid-FWD does not abort the transaction; it completes normally or times out.

Decomposition:
- Package macro_arb_pkg holds:
  - state enum {IDLE, FWD, RESP};
  - SLOT_CTRL=4'hF, BASE_HI=8'h30;
  - register offsets for ENABLE, IO_OWNER and TO_CNT;
  - ERR_DATA and BAD_DATA.
- One sub-module, macro_io_mux: registered N-to-1 pad mux with the safe default.
- FSM, decode and registers stay in the top module.

Test Plan:
- Write 0x30F00000 = 0x5, then read it back -> ack 1 cycle after stb; m_active_o=4'b0101; read data 0x5.
- ENABLE=0x1; read 0x30000010; macro 0 acks after 3 cycles with 0x12345678 -> m_stb_o=4'b0001 only; wbs_dat_o=0x12345678; one ack pulse.
- ENABLE=0x1; read 0x30100000 (slot 1 disabled) -> ack at cycle 1, data 0xBADD_ADD0, m_stb_o stays 0.
- Read macro 0 with no ack, TIMEOUT=255 -> ack at cycle 256, data 0xDEAD_BEEF; TO_CNT reads 1; 256 further timeouts leave TO_CNT saturated at 255; write 0x30F00008 clears it to 0.
- ENABLE=0x4, IO_OWNER=2, macro 2 drives io_out=0x15, io_oeb=0 -> pads show those values 1 cycle later; clear ENABLE -> io_oeb=all 1, io_out=0.
- Assert wb_rst_n=0 mid-FWD -> next cycle: m_stb_o=0, wbs_ack_o=0, ENABLE=0, state IDLE, no spurious ack after reset is released.

Source files
------------

// File: rtl/macro_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : macro_arb_pkg
//  Description : Shared constants for the macro bus arbiter: FSM encoding,
//                address map fields, control register offsets and the
//                read data returned for error and invalid accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
package macro_arb_pkg;

    // Arbiter FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Address map: adr[31:24] must equal BASE_HI, adr[23:20] is the slot
    localparam logic [7:0] BASE_HI   = 8'h30;
    localparam logic [3:0] SLOT_CTRL = 4'hF;

    // Control register offsets, decoded on adr[3:2]
    localparam logic [1:0] REG_ENABLE   = 2'd0;
    localparam logic [1:0] REG_IO_OWNER = 2'd1;
    localparam logic [1:0] REG_TO_CNT   = 2'd2;

    // Read data returned on macro timeout and on invalid/disabled slots
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] BAD_DATA = 32'hBADD_ADD0;

endpackage
`default_nettype wire

// File: rtl/macro_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : macro_bus_arbiter_if
//  Description : Caravel Wishbone slave port bundle. The arbiter uses the
//                slave modport; the management-side driver uses master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface macro_bus_arbiter_if;
    import macro_arb_pkg::*;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface
`default_nettype wire

// File: rtl/macro_bus_arbiter_io_mux.sv
`default_nettype none
// ============================================================================
//  Module      : macro_io_mux
//  Description : Registered N-to-1 IO pad mux. The owner's pad drive is
//                passed through only when the owner index is a real slot
//                and that slot is enabled; otherwise pads are parked as
//                inputs (io_oeb all ones, io_out zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module macro_io_mux
    import macro_arb_pkg::*;
#(
    parameter int N_MACRO = 4,
    parameter int IO_W    = 38
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_MACRO-1:0]      i_enable,
    input  logic [3:0]              i_owner,
    input  logic [N_MACRO*IO_W-1:0] i_io_out,
    input  logic [N_MACRO*IO_W-1:0] i_io_oeb,
    output logic [IO_W-1:0]         o_io_out,
    output logic [IO_W-1:0]         o_io_oeb
);

    // Slices padded to 16 entries so the 4-bit owner indexes them directly
    logic [IO_W-1:0] w_out_pad [16];
    logic [IO_W-1:0] w_oeb_pad [16];
    logic [15:0]     w_en_pad;
    logic            w_valid;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pad
        if (gi < N_MACRO) begin : g_live
            assign w_out_pad[gi] = i_io_out[gi*IO_W +: IO_W];
            assign w_oeb_pad[gi] = i_io_oeb[gi*IO_W +: IO_W];
        end else begin : g_dead
            assign w_out_pad[gi] = '0;
            assign w_oeb_pad[gi] = '1;
        end
    end

    assign w_en_pad = 16'(i_enable);
    assign w_valid  = (i_owner < 4'(N_MACRO)) && w_en_pad[i_owner];

    // Register the selected pad drive, falling back to the safe parked state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_io_out <= '0;
            o_io_oeb <= '1;
        end else if (w_valid) begin
            o_io_out <= w_out_pad[i_owner];
            o_io_oeb <= w_oeb_pad[i_owner];
        end else begin
            o_io_out <= '0;
            o_io_oeb <= '1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/macro_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : macro_bus_arbiter
//  Description : Shares the Caravel Wishbone slave port and IO pads among
//                N_MACRO user macros. Decodes each transaction to one macro
//                slot or the control block, forwards it with a bounded
//                timeout, and holds the ENABLE / IO_OWNER / TO_CNT registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module macro_bus_arbiter
    import macro_arb_pkg::*;
#(
    parameter int          N_MACRO  = 4,
    parameter int          TIMEOUT  = 255,
    parameter int          IO_W     = 38,
    parameter logic [31:0] ERR_DATA = macro_arb_pkg::ERR_DATA,
    parameter logic [31:0] BAD_DATA = macro_arb_pkg::BAD_DATA
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    macro_bus_arbiter_if.slave      wbs,
    output logic [N_MACRO-1:0]      m_cyc_o,
    output logic [N_MACRO-1:0]      m_stb_o,
    output logic                    m_we_o,
    output logic [3:0]              m_sel_o,
    output logic [31:0]             m_adr_o,
    output logic [31:0]             m_dat_o,
    input  logic [N_MACRO*32-1:0]   m_dat_i,
    input  logic [N_MACRO-1:0]      m_ack_i,
    output logic [N_MACRO-1:0]      m_active_o,
    input  logic [N_MACRO*IO_W-1:0] m_io_out_i,
    input  logic [N_MACRO*IO_W-1:0] m_io_oeb_i,
    output logic [IO_W-1:0]         io_out,
    output logic [IO_W-1:0]         io_oeb
);

    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [31:0]        r_dat;
    logic [N_MACRO-1:0] r_cyc;
    logic [N_MACRO-1:0] r_enable;
    logic [3:0]         r_owner;
    logic [3:0]         r_sel;
    logic [7:0]         r_to_cnt;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_req;
    logic [3:0]         w_slot;
    logic [1:0]         w_reg_off;
    logic               w_is_ctrl;
    logic               w_is_macro;
    logic [31:0]        w_ctrl_rdata;
    logic [N_MACRO-1:0] w_onehot;
    logic [15:0]        w_en_pad;
    logic [15:0]        w_ack_pad;
    logic [31:0]        w_dat_pad [16];

    // Per-slot read data padded to 16 entries so the latched slot indexes it
    for (genvar gi = 0; gi < 16; gi++) begin : g_dat_pad
        if (gi < N_MACRO) begin : g_live
            assign w_dat_pad[gi] = m_dat_i[gi*32 +: 32];
        end else begin : g_dead
            assign w_dat_pad[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < N_MACRO; gi++) begin : g_onehot
        assign w_onehot[gi] = (w_slot == 4'(gi));
    end

    // Address decode of the current master request
    assign w_req      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_slot     = wbs.wbs_adr_i[23:20];
    assign w_reg_off  = wbs.wbs_adr_i[3:2];
    assign w_en_pad   = 16'(r_enable);
    assign w_ack_pad  = 16'(m_ack_i);
    assign w_is_ctrl  = (wbs.wbs_adr_i[31:24] == BASE_HI) && (w_slot == SLOT_CTRL);
    assign w_is_macro = (wbs.wbs_adr_i[31:24] == BASE_HI) && (w_slot < 4'(N_MACRO))
                        && w_en_pad[w_slot];

    // Control register read mux
    always_comb begin
        w_ctrl_rdata = '0;
        case (w_reg_off)
            REG_ENABLE:   w_ctrl_rdata = 32'(r_enable);
            REG_IO_OWNER: w_ctrl_rdata = {28'd0, r_owner};
            REG_TO_CNT:   w_ctrl_rdata = {24'd0, r_to_cnt};
            default:      w_ctrl_rdata = '0;
        endcase
    end

    // Transaction FSM, control registers and timeout bookkeeping
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state  <= S_IDLE;
            r_dat    <= '0;
            r_cyc    <= '0;
            r_enable <= '0;
            r_owner  <= '0;
            r_sel    <= '0;
            r_to_cnt <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_is_ctrl) begin
                            if (wbs.wbs_we_i) begin
                                case (w_reg_off)
                                    REG_ENABLE:   r_enable <= wbs.wbs_dat_i[N_MACRO-1:0];
                                    REG_IO_OWNER: r_owner  <= wbs.wbs_dat_i[3:0];
                                    REG_TO_CNT:   r_to_cnt <= '0;
                                    default:      ;
                                endcase
                            end else begin
                                r_dat <= w_ctrl_rdata;
                            end
                            r_state <= S_RESP;
                        end else if (w_is_macro) begin
                            r_sel   <= w_slot;
                            r_cyc   <= w_onehot;
                            r_cnt   <= '0;
                            r_state <= S_FWD;
                        end else begin
                            r_dat   <= BAD_DATA;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_FWD: begin
                    // A vanished master takes priority: nobody is left to ack
                    if (!wbs.wbs_cyc_i) begin
                        r_cyc   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_ack_pad[r_sel]) begin
                        r_dat   <= w_dat_pad[r_sel];
                        r_cyc   <= '0;
                        r_state <= S_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_dat   <= ERR_DATA;
                        r_cyc   <= '0;
                        r_state <= S_RESP;
                        if (r_to_cnt != 8'hFF) begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs.wbs_ack_o = (r_state == S_RESP);
    assign wbs.wbs_dat_o = r_dat;

    assign m_cyc_o    = r_cyc;
    assign m_stb_o    = r_cyc;
    assign m_we_o     = wbs.wbs_we_i;
    assign m_sel_o    = wbs.wbs_sel_i;
    assign m_adr_o    = wbs.wbs_adr_i;
    assign m_dat_o    = wbs.wbs_dat_i;
    assign m_active_o = r_enable;

    macro_io_mux #(
        .N_MACRO (N_MACRO),
        .IO_W    (IO_W)
    ) u_io_mux (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .i_enable (r_enable),
        .i_owner  (r_owner),
        .i_io_out (m_io_out_i),
        .i_io_oeb (m_io_oeb_i),
        .o_io_out (io_out),
        .o_io_oeb (io_oeb)
    );

endmodule
`default_nettype wire

// File: tb/tb_macro_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_macro_bus_arbiter
//  Description : Self-checking bench for macro_bus_arbiter. Directed cases
//                plus randomized transactions against a transaction-level
//                reference model of the address map and register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_macro_bus_arbiter;
    import macro_arb_pkg::*;

    localparam int N   = 4;
    localparam int TO  = 255;
    localparam int IOW = 38;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    macro_bus_arbiter_if wbs ();

    logic [N-1:0]     m_cyc_o, m_stb_o, m_active_o, m_ack_i;
    logic             m_we_o;
    logic [3:0]       m_sel_o;
    logic [31:0]      m_adr_o, m_dat_o;
    logic [N*32-1:0]  m_dat_i;
    logic [N*IOW-1:0] m_io_out_i, m_io_oeb_i;
    logic [IOW-1:0]   io_out, io_oeb;

    macro_bus_arbiter #(.N_MACRO(N), .TIMEOUT(TO), .IO_W(IOW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .wbs        (wbs),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_we_o     (m_we_o),
        .m_sel_o    (m_sel_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_dat_i    (m_dat_i),
        .m_ack_i    (m_ack_i),
        .m_active_o (m_active_o),
        .m_io_out_i (m_io_out_i),
        .m_io_oeb_i (m_io_oeb_i),
        .io_out     (io_out),
        .io_oeb     (io_oeb)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: register file as the master sees it
    logic [N-1:0] md_en;
    logic [3:0]   md_own;
    int           md_to;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        md_en  = '0;
        md_own = '0;
        md_to  = 0;
    endtask

    // Predict latency, read data and which macro strobe appears
    task automatic model_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                             input int ack_at, output int lat, output logic [31:0] dat,
                             output bit dv, output logic [N-1:0] stb);
        int slot;
        slot = int'(adr[23:20]);
        lat  = 1;
        dat  = BAD_DATA;
        dv   = 1'b1;
        stb  = '0;
        if (adr[31:24] != 8'h30) begin
            dv = 1'b1;
        end else if (slot == 15) begin
            dv  = !we;
            dat = 32'd0;
            case (int'(adr[3:2]))
                0: if (we) md_en = wdat[N-1:0]; else dat = 32'(md_en);
                1: if (we) md_own = wdat[3:0]; else dat = 32'(md_own);
                2: if (we) md_to = 0; else dat = 32'(md_to);
                default: dat = 32'd0;
            endcase
        end else if (slot < N && md_en[slot]) begin
            stb = N'(1) << slot;
            if (ack_at >= 1 && ack_at <= TO) begin
                lat = ack_at + 1;
                dat = m_dat_i[slot*32 +: 32];
            end else begin
                lat = TO + 1;
                dat = ERR_DATA;
                if (md_to < 255) md_to++;
            end
        end
    endtask

    // One Wishbone transaction; the selected macro acks in cycle ack_at (0 = never)
    task automatic run(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input int ack_at, input string tag);
        int           elat, lat;
        logic [31:0]  edat, rdat;
        bit           dv;
        logic [N-1:0] estb, stb_seen;
        model_txn(adr, we, wdat, ack_at, elat, edat, dv, estb);
        lat = -1; rdat = '0; stb_seen = '0;
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
        wbs.wbs_adr_i = adr;  wbs.wbs_dat_i = wdat; wbs.wbs_sel_i = 4'hF;
        for (int n = 1; n <= TO + 20 && lat < 0; n++) begin
            @(negedge clk);
            stb_seen |= m_stb_o;
            if (n == 1 && estb != '0) begin
                chk({tag, "/bcast_adr"}, 64'(m_adr_o), 64'(adr));
                chk({tag, "/bcast_we"},  64'(m_we_o),  64'(we));
            end
            if (wbs.wbs_ack_o) begin
                lat  = n;
                rdat = wbs.wbs_dat_o;
                wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
                m_ack_i = '0;
            end else begin
                m_ack_i = N'($urandom) & ~m_stb_o;
                if (n == ack_at) m_ack_i = m_ack_i | m_stb_o;
            end
        end
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; m_ack_i = '0;
        chk({tag, "/latency"}, 64'(lat), 64'(elat));
        if (dv) chk({tag, "/rdata"}, 64'(rdat), 64'(edat));
        chk({tag, "/stb"}, 64'(stb_seen), 64'(estb));
        @(negedge clk);
        chk({tag, "/ack_once"}, 64'({wbs.wbs_ack_o, m_stb_o}), 64'd0);
    endtask

    task automatic chk_io(input string tag);
        logic [IOW-1:0] eo, ee;
        eo = '0; ee = '1;
        if (int'(md_own) < N && md_en[md_own]) begin
            eo = m_io_out_i[int'(md_own)*IOW +: IOW];
            ee = m_io_oeb_i[int'(md_own)*IOW +: IOW];
        end
        chk({tag, "/io_out"}, 64'(io_out), 64'(eo));
        chk({tag, "/io_oeb"}, 64'(io_oeb), 64'(ee));
    endtask

    task automatic fill_dat();
        for (int i = 0; i < N; i++) m_dat_i[i*32 +: 32] = $urandom;
    endtask

    task automatic fill_io();
        for (int i = 0; i < N * IOW; i++) begin
            m_io_out_i[i] = 1'($urandom_range(0, 1));
            m_io_oeb_i[i] = 1'($urandom_range(0, 1));
        end
    endtask

    logic [31:0]  a, d;
    logic         w;
    logic [N-1:0] seen;
    int           r, ack, to_budget;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0; wbs.wbs_we_i = 0;
        wbs.wbs_sel_i = 0; wbs.wbs_adr_i = 0; wbs.wbs_dat_i = 0;
        m_ack_i = '0;
        fill_dat();
        fill_io();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst/ack",    64'(wbs.wbs_ack_o), 64'd0);
        chk("rst/dat",    64'(wbs.wbs_dat_o), 64'd0);
        chk("rst/stb",    64'({m_cyc_o, m_stb_o}), 64'd0);
        chk("rst/active", 64'(m_active_o), 64'd0);
        chk_io("rst");
        rst_n = 1'b1;

        // ENABLE write and readback
        run(32'h30F0_0000, 1, 32'h5, 0, "en_wr");
        chk("en/active", 64'(m_active_o), 64'b0101);
        run(32'h30F0_0000, 0, 0, 0, "en_rd");

        // Macro 0 read acked in cycle 3
        run(32'h30F0_0000, 1, 32'h1, 0, "en1");
        m_dat_i[31:0] = 32'h1234_5678;
        run(32'h3000_0010, 0, 0, 3, "m0_rd");

        // Disabled slot
        run(32'h3010_0000, 0, 0, 2, "dis_slot");

        // Timeout, counter and saturation
        run(32'h3000_0000, 0, 0, 0, "tmo");
        run(32'h30F0_0008, 0, 0, 0, "tocnt1");
        for (int i = 0; i < 256; i++) run(32'h3000_0000, 0, 0, 0, "tmo_sat");
        run(32'h30F0_0008, 0, 0, 0, "tocnt_sat");
        run(32'h30F0_0008, 1, 32'h0, 0, "tocnt_clr");
        run(32'h30F0_0008, 0, 0, 0, "tocnt0");

        // IO ownership
        m_io_out_i[2*IOW +: IOW] = IOW'(38'h15);
        m_io_oeb_i[2*IOW +: IOW] = '0;
        run(32'h30F0_0000, 1, 32'h4, 0, "io_en");
        run(32'h30F0_0004, 1, 32'h2, 0, "io_own");
        chk_io("io_owner2");
        m_io_out_i[2*IOW +: IOW] = IOW'(38'h2A);
        @(negedge clk);
        chk_io("io_follow");
        run(32'h30F0_0000, 1, 32'h0, 0, "io_dis");
        chk_io("io_parked");

        // Master abort mid-forward
        run(32'h30F0_0000, 1, 32'h1, 0, "ab_en");
        @(negedge clk);
        wbs.wbs_cyc_i = 1; wbs.wbs_stb_i = 1; wbs.wbs_we_i = 0; wbs.wbs_adr_i = 32'h3000_0000;
        repeat (3) @(negedge clk);
        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen |= m_stb_o | N'(wbs.wbs_ack_o);
        end
        chk("abort/quiet", 64'(seen), 64'd0);
        run(32'h3000_0000, 0, 0, 2, "after_abort");

        // Reset mid-forward
        @(negedge clk);
        wbs.wbs_cyc_i = 1; wbs.wbs_stb_i = 1; wbs.wbs_we_i = 0; wbs.wbs_adr_i = 32'h3000_0000;
        repeat (4) @(negedge clk);
        chk("rstfwd/pre_stb", 64'(m_stb_o), 64'b0001);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        chk("rstfwd/stb",    64'(m_stb_o), 64'd0);
        chk("rstfwd/ack",    64'(wbs.wbs_ack_o), 64'd0);
        chk("rstfwd/active", 64'(m_active_o), 64'd0);
        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0;
        rst_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen |= m_stb_o | N'(wbs.wbs_ack_o);
        end
        chk("rstfwd/quiet", 64'(seen), 64'd0);
        chk_io("rstfwd");
        run(32'h30F0_0000, 0, 0, 0, "rstfwd_en");

        // Randomized traffic
        to_budget = 3;
        for (int t = 0; t < 80; t++) begin
            fill_dat();
            r   = $urandom_range(0, 9);
            d   = $urandom;
            w   = 1'($urandom_range(0, 1));
            ack = $urandom_range(1, 12);
            if (r == 0) begin
                a = {8'($urandom_range(8'h31, 8'hFF)), 24'($urandom)};
            end else if (r <= 3) begin
                a = {8'h30, 4'hF, 16'($urandom), 2'($urandom_range(0, 3)), 2'b00};
                if ($urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 6));
            end else begin
                a = {8'h30, 4'($urandom_range(0, 5)), 20'($urandom)};
                if (to_budget > 0 && $urandom_range(0, 19) == 0) begin
                    ack = 0;
                    to_budget--;
                end
            end
            run(a, w, d, ack, "rnd");
            chk_io("rnd");
            if ($urandom_range(0, 3) == 0) begin
                fill_io();
                @(negedge clk);
                chk_io("rnd_refill");
            end
        end
        run(32'h30F0_0000, 0, 0, 0, "final_en");
        run(32'h30F0_0008, 0, 0, 0, "final_tocnt");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
